// File: rtl/trace_repository_datatypes.sv
// Shared trace-repository types: entry layout, index width, opcode
// constants and the dispatcher state encoding.
package trace_repository_datatypes;

  localparam int TRACE_ENTRIES     = 16;
  localparam int TRACE_INDEX_WIDTH = $clog2(TRACE_ENTRIES);
  localparam int REPO_ADDR_WIDTH   = 16;

  localparam logic [6:0] OPC_LOAD  = 7'h03;
  localparam logic [6:0] OPC_STORE = 7'h23;

  // One repository entry: the traced instruction word and the data address
  // it touched (meaningful only for loads and stores).
  typedef struct packed {
    logic [31:0]                instruction;
    logic [REPO_ADDR_WIDTH-1:0] mem_addr;
  } trace_repo_data_entry;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    REQUEST    = 3'd1,
    CANCELLING = 3'd2,
    MARK_START = 3'd3,
    PRELOAD    = 3'd4,
    WAIT_RESP  = 3'd5,
    MARK_END   = 3'd6,
    FINISHED   = 3'd7
  } dispatch_state_t;

  function automatic logic is_mem_op(input logic [6:0] opcode);
    return (opcode == OPC_LOAD) || (opcode == OPC_STORE);
  endfunction

  function automatic logic is_store_op(input logic [6:0] opcode);
    return opcode == OPC_STORE;
  endfunction

endpackage

// File: rtl/trace_dispatcher.sv
// Trace dispatcher: pulls entries from a locked trace repository, marks
// memory entries as in-flight, preloads their data address into the data
// cache and marks them retired.
//
// Handshakes: every request output (trace_req, cancel, mark_done, pf_req)
// is held high until its acknowledge input (entry_valid / cancelled /
// processing_complete, cancelled, mark_done_valid, pf_gnt) is sampled high
// at a rising edge; the request drops on that same edge and any payload
// driven alongside it stays stable for the whole time the request is high.
module trace_dispatcher
  import trace_repository_datatypes::*;
#(
  parameter int DATA_ADDR_WIDTH = 16,
  parameter int CANCEL_TIMEOUT  = 15
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  output logic                         trace_req,
  output logic                         cancel,
  input  trace_repo_data_entry         trace_in,
  input  logic [TRACE_INDEX_WIDTH-1:0] trace_index_i,
  input  logic                         entry_valid,
  input  logic                         cancelled,
  input  logic                         processing_complete,
  output logic                         mark_done,
  output logic [TRACE_INDEX_WIDTH-1:0] index_done,
  output logic                         processing_flag,
  output logic                         mem_trace_flag,
  output logic [DATA_ADDR_WIDTH-1:0]   mem_addr,
  input  logic                         mark_done_valid,
  output logic                         pf_req,
  output logic [DATA_ADDR_WIDTH-1:0]   pf_addr,
  output logic                         pf_we,
  input  logic                         pf_gnt,
  input  logic                         pf_rvalid,
  output logic                         done,
  output logic [15:0]                  dispatched_count,
  output logic [2:0]                   fsm_state
);

  localparam int CNT_W = (CANCEL_TIMEOUT < 1) ? 1 : $clog2(CANCEL_TIMEOUT + 1);

  dispatch_state_t state, state_next;

  logic [TRACE_INDEX_WIDTH-1:0] idx_q;
  logic [DATA_ADDR_WIDTH-1:0]   addr_q;
  logic                         store_q;
  logic [CNT_W-1:0]             cancel_cnt_q;
  logic [CNT_W-1:0]             cancel_cnt_inc;
  logic [15:0]                  count_q;
  logic                         entry_is_mem;
  logic                         unused_instr_bits;

  assign entry_is_mem      = is_mem_op(trace_in.instruction[6:0]);
  assign cancel_cnt_inc    = cancel_cnt_q + CNT_W'(1);
  assign unused_instr_bits = ^trace_in.instruction[31:7];

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; losing enable aborts any activity back to IDLE.
  always_comb begin
    state_next = state;
    if (state != IDLE && !enable) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:       if (enable) state_next = REQUEST;
        REQUEST: begin
          // entry_valid outranks a simultaneous cancelled.
          if (entry_valid)              state_next = entry_is_mem ? MARK_START : MARK_END;
          else if (processing_complete) state_next = FINISHED;
          else if (cancelled)           state_next = IDLE;
          else if (cancel_cnt_inc == CNT_W'(CANCEL_TIMEOUT)) state_next = CANCELLING;
        end
        CANCELLING: if (cancelled)       state_next = IDLE;
        MARK_START: if (mark_done_valid) state_next = PRELOAD;
        PRELOAD:    if (pf_gnt)          state_next = WAIT_RESP;
        WAIT_RESP:  if (pf_rvalid)       state_next = MARK_END;
        MARK_END:   if (mark_done_valid) state_next = REQUEST;
        FINISHED:   state_next = FINISHED;
        default:    state_next = IDLE;
      endcase
    end
  end

  // Latch the accepted entry so mark/preload payloads stay stable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q   <= '0;
      addr_q  <= '0;
      store_q <= 1'b0;
    end else if (state == REQUEST && enable && entry_valid) begin
      idx_q   <= trace_index_i;
      addr_q  <= DATA_ADDR_WIDTH'(trace_in.mem_addr);
      store_q <= is_store_op(trace_in.instruction[6:0]);
    end
  end

  // Cancel counter: counts request cycles, cleared whenever REQUEST is left.
  always_ff @(posedge clk) begin
    if (!rst_n)                                          cancel_cnt_q <= '0;
    else if (state == REQUEST && state_next == REQUEST)  cancel_cnt_q <= cancel_cnt_inc;
    else                                                 cancel_cnt_q <= '0;
  end

  // Count retired entries, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (state == MARK_END && state_next == REQUEST && count_q != 16'hFFFF) begin
      count_q <= count_q + 16'd1;
    end
  end

  // Moore outputs decoded from the current state and latched entry.
  always_comb begin
    trace_req       = 1'b0;
    cancel          = 1'b0;
    mark_done       = 1'b0;
    processing_flag = 1'b0;
    mem_trace_flag  = 1'b0;
    index_done      = '0;
    mem_addr        = '0;
    pf_req          = 1'b0;
    pf_addr         = '0;
    pf_we           = 1'b0;
    done            = 1'b0;
    case (state)
      REQUEST:    trace_req = 1'b1;
      CANCELLING: begin
        trace_req = 1'b1;
        cancel    = 1'b1;
      end
      MARK_START: begin
        mark_done       = 1'b1;
        processing_flag = 1'b1;
        mem_trace_flag  = 1'b1;
        index_done      = idx_q;
        mem_addr        = addr_q;
      end
      PRELOAD: begin
        pf_req  = 1'b1;
        pf_addr = addr_q;
        pf_we   = store_q;
      end
      MARK_END: begin
        mark_done      = 1'b1;
        mem_trace_flag = 1'b1;
        index_done     = idx_q;
        mem_addr       = addr_q;
      end
      FINISHED:   done = 1'b1;
      default:    ;
    endcase
  end

  assign dispatched_count = count_q;
  assign fsm_state        = state;

endmodule

// File: doc/trace_dispatcher.md
TRACE_DISPATCHER -- requirements
Module: trace_dispatcher

Interface
REQ-001 SHALL have parameter DATA_ADDR_WIDTH, default 16, data address width.
REQ-002 SHALL have parameter CANCEL_TIMEOUT, default 15, number of trace_req cycles before cancel is raised.
REQ-003 SHALL have ports clk in 1 (clock) and rst_n in 1 (reset); reset is synchronous, active-low; clock is clk.
REQ-004 SHALL have port enable in 1: repository locked; dispatching permitted.
REQ-005 SHALL have ports trace_req out 1 and cancel out 1: requests to the repository.
REQ-006 SHALL have ports trace_in in trace_repo_data_entry, trace_index_i in TRACE_INDEX_WIDTH, entry_valid in 1, cancelled in 1 and processing_complete in 1.
REQ-007 SHALL have ports mark_done out 1, index_done out TRACE_INDEX_WIDTH, processing_flag out 1, mem_trace_flag out 1, mem_addr out DATA_ADDR_WIDTH and mark_done_valid in 1.
REQ-008 SHALL have ports pf_req out 1, pf_addr out DATA_ADDR_WIDTH, pf_we out 1, pf_gnt in 1 and pf_rvalid in 1: preload port to the data cache.
REQ-009 SHALL have ports done out 1 and dispatched_count out 16.

Function
REQ-010 SHALL implement the states IDLE, REQUEST, CANCELLING, MARK_START, PRELOAD, WAIT_RESP, MARK_END and FINISHED.
REQ-011 IDLE SHALL go to REQUEST when enable=1; every non-IDLE state SHALL return to IDLE on the next edge when enable=0.
REQ-012 In REQUEST, trace_req SHALL be 1 and held until entry_valid, cancelled or processing_complete is seen.
REQ-013 processing_complete=1 in REQUEST SHALL go to FINISHED, which holds done=1 until enable=0 or reset.
REQ-014 On entry_valid, the block SHALL latch trace_in and trace_index_i, drop trace_req the same edge and classify the entry.
REQ-015 An entry SHALL be a memory trace when instruction[6:0] is 7'h03 (load) or 7'h23 (store).
REQ-016 A memory entry SHALL go to MARK_START; a non-memory entry SHALL go directly to MARK_END.
REQ-017 MARK_START SHALL drive mark_done=1, processing_flag=1, mem_trace_flag=1, index_done=latched index and mem_addr=latched mem_addr.
REQ-018 Every mark handshake SHALL hold mark_done until the cycle mark_done_valid=1, deassert mark_done on the following edge, and keep all flag/address outputs stable while mark_done=1.
REQ-019 PRELOAD SHALL hold pf_req=1 with pf_addr=mem_addr, and pf_we=1 for a store, until pf_gnt=1, then go to WAIT_RESP.
REQ-020 WAIT_RESP SHALL wait for pf_rvalid=1 with no timeout, then go to MARK_END.
REQ-021 MARK_END SHALL drive mark_done=1, processing_flag=0, mem_trace_flag=1 and the same index/address, then return to REQUEST.
REQ-022 The cancel counter SHALL count cycles with trace_req=1 and reset on leaving REQUEST.
REQ-023 When the cancel counter reaches CANCEL_TIMEOUT, the block SHALL enter CANCELLING with cancel=1 and trace_req=1.
REQ-024 CANCELLING SHALL drop both signals when cancelled=1 and go to IDLE.
REQ-025 If entry_valid and cancelled are seen in the same cycle, entry_valid SHALL win and cancelled SHALL be ignored.
REQ-026 dispatched_count SHALL increment by 1 on each completed MARK_END handshake and saturate at 16'hFFFF.
REQ-027 trace_req and mark_done SHALL never both be 1.
REQ-028 pf_req SHALL be 1 only in PRELOAD.

Reset
REQ-029 With rst_n=0 at an edge, the block SHALL enter IDLE and clear to 0 all outputs, the latched entry, the cancel counter and dispatched_count, including mid-handshake.
REQ-030 After reset release, no output SHALL change before the first edge with enable=1.

Structure
REQ-031 TRACE_INDEX_WIDTH (=$clog2(TRACE_ENTRIES)), the opcode constants and the state enum SHALL live in trace_repository_datatypes.
REQ-032 trace_repo_data_entry SHALL be reused from trace_repository_datatypes without redefinition.
REQ-033 The block SHALL be a single module with no sub-modules; the cancel counter is inline.

Verification
REQ-034 The bench SHALL cover: load entry idx 3, addr 16'h0040 -> mark_done(proc=1) -> pf_req addr 16'h0040, pf_we=0 -> pf_rvalid -> mark_done(proc=0), dispatched_count=1.
REQ-035 The bench SHALL cover: non-memory entry (opcode 7'h13) idx 5 -> no pf_req; a single mark_done with processing_flag=0, index_done=5.
REQ-036 The bench SHALL cover: no entry_valid for 15 cycles -> cancel=1 on cycle 16; cancelled=1 -> cancel and trace_req both 0 next cycle, then IDLE.
REQ-037 The bench SHALL cover: processing_complete during REQUEST -> done=1 held; enable dropped -> done=0.
REQ-038 The bench SHALL cover: mark_done_valid delayed 4 cycles -> mark_done held 4 cycles with stable outputs, deasserted 1 cycle after valid.
REQ-039 The bench SHALL cover: rst_n=0 during WAIT_RESP -> all outputs 0 next edge and state IDLE.
